demux8_16b_reg: RTL and testbench

Registered 8-way, 16-bit write demultiplexer; the write-side counterpart of the 8:1 16-bit read mux in the processor datapath. It accepts one 16-bit value per handshake and steers it into one of eight holding registers a–h, all of which are presented in parallel. It supports single writes, auto-incrementing burst writes, and a sequenced 8-cycle bank clear. Its outputs feed datapath consumers that previously sourced fixed inputs of the read mux.

---
 rtl/demux8_16b_reg.sv | 147 ++++++++++++++
 tb/tb_demux8_16b_reg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux8_16b_reg.sv
// demux8_16b_reg
//
// Registered 8-way, 16-bit write demultiplexer. One 16-bit value is accepted
// per handshake and steered into one of eight holding registers a..h, all of
// which are presented in parallel. Supports single writes, auto-incrementing
// burst writes (wrapping h -> a) and a sequenced 8-cycle bank clear.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   in[15:0]   write data
//   sel[2:0]   destination register in IDLE (0=a ... 7=h), ignored in BURST
//   wr_valid   write request
//   wr_ready   combinational: not clearing and clr not asserted
//   auto_inc   sampled on each accepted write; starts or continues a burst
//   clr        starts an 8-cycle bank clear when not already clearing
//   be[1:0]    byte enables (only with DEMUX8_BYTE_EN defined)
//   a..h       holding registers
//   upd[7:0]   registered one-cycle strobe, bit i = register i was written
//   busy       high while the bank clear is running
//
// Configuration macro: DEMUX8_BYTE_EN adds the be[1:0] byte-enable input.
module demux8_16b_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic [2:0]  sel,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        auto_inc,
`ifdef DEMUX8_BYTE_EN
  input  logic [1:0]  be,
`endif
  input  logic        clr,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic [15:0] d,
  output logic [15:0] e,
  output logic [15:0] f,
  output logic [15:0] g,
  output logic [15:0] h,
  output logic [7:0]  upd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [7:0]  upd_q, upd_d;

  logic        accept;
  logic [2:0]  target;
  logic [15:0] wmask;

  // clr blocks the handshake combinationally so a write presented in the
  // same cycle as clr is never taken.
  assign wr_ready = (state_q != CLEAR) && !clr;
  assign accept   = wr_valid && wr_ready;

  // In a burst the write pointer replaces sel as the destination.
  assign target = (state_q == BURST) ? ptr_q : sel;

`ifdef DEMUX8_BYTE_EN
  assign wmask = {{8{be[1]}}, {8{be[0]}}};
`else
  assign wmask = 16'hFFFF;
`endif

  // Next-state logic. A write with no enabled bytes still moves the pointer
  // and state machine, but leaves data alone and raises no upd strobe.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    upd_d   = 8'h00;
    regs_d  = regs_q;

    case (state_q)
      CLEAR: begin
        regs_d[cnt_q] = 16'h0000;
        cnt_d         = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
        end else if (accept) begin
          regs_d[target] = (regs_q[target] & ~wmask) | (in & wmask);
          if (wmask != 16'h0000) begin
            upd_d[target] = 1'b1;
          end
          if (auto_inc) begin
            ptr_d   = target + 3'd1;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // State and register bank update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 3'd0;
      upd_q   <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign a    = regs_q[0];
  assign b    = regs_q[1];
  assign c    = regs_q[2];
  assign d    = regs_q[3];
  assign e    = regs_q[4];
  assign f    = regs_q[5];
  assign g    = regs_q[6];
  assign h    = regs_q[7];
  assign upd  = upd_q;
  assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_demux8_16b_reg.sv
// Testbench for demux8_16b_reg.
//
// The driver applies stimulus on the falling edge, advances a behavioural
// model of the register bank (plain arrays plus a "burst pointer" and a
// "clear position") and pushes every expected write, stamped with the clock
// edge that should perform it, into a scoreboard queue. A separate monitor
// pops those entries on each falling edge and compares upd and the written
// register. The driver additionally compares the whole bank and busy against
// the model every cycle, and wr_ready right after driving clr.
module tb_demux8_16b_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic [2:0]  sel;
  logic        wrValid;
  logic        wrReady;
  logic        autoInc;
  logic        clr;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  upd;
  logic        busy;
`ifdef DEMUX8_BYTE_EN
  logic [1:0]  be = 2'b11;
`endif

  always #5 clk = ~clk;

  demux8_16b_reg dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .sel      (sel),
    .wr_valid (wrValid),
    .wr_ready (wrReady),
    .auto_inc (autoInc),
`ifdef DEMUX8_BYTE_EN
    .be       (be),
`endif
    .clr      (clr),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .upd      (upd),
    .busy     (busy)
  );

  logic [15:0] dutRegs [8];
  assign dutRegs[0] = a;
  assign dutRegs[1] = b;
  assign dutRegs[2] = c;
  assign dutRegs[3] = d;
  assign dutRegs[4] = e;
  assign dutRegs[5] = f;
  assign dutRegs[6] = g;
  assign dutRegs[7] = h;

  int checkCount = 0;
  int passCount  = 0;

  // Edge counter used to stamp scoreboard entries.
  int edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  typedef struct {
    int          stamp;
    int          idx;
    logic [15:0] data;
  } exp_t;
  exp_t expQ[$];

  // Behavioural model: the bank contents, whether a burst is running and
  // where it will write next, and how far a bank clear has progressed.
  logic [15:0] mReg [8];
  bit          mBurst;
  int          mPtr;
  bit          mClearing;
  int          mCnt;
  bit          monOn = 1'b0;

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mReg[i] = 16'h0000;
    mBurst    = 1'b0;
    mPtr      = 0;
    mClearing = 1'b0;
    mCnt      = 0;
  endtask

  // Whole-bank and busy comparison against the model (model holds the state
  // after the most recent edge).
  task automatic checkOutput();
    for (int i = 0; i < 8; i++) begin
      compareValue($sformatf("reg%0d", i), {16'h0, dutRegs[i]}, {16'h0, mReg[i]});
    end
    compareValue("busy", {31'h0, busy}, {31'h0, mClearing});
  endtask

  // Called on a falling edge: check, drive one cycle, advance the model for
  // the coming rising edge, then wait for the next falling edge.
  task automatic applyStimulus(input bit v, input logic [2:0] s, input logic [15:0] dat,
                               input bit ai, input bit cl);
    int          tgt;
    logic [15:0] mask;
    logic [15:0] newVal;
    checkOutput();
    wrValid = v;
    sel     = s;
    in      = dat;
    autoInc = ai;
    clr     = cl;
    #1;
    compareValue("wr_ready", {31'h0, wrReady}, {31'h0, (!mClearing && !cl)});
    if (mClearing) begin
      mReg[mCnt] = 16'h0000;
      mCnt++;
      if (mCnt == 8) mClearing = 1'b0;
    end else if (cl) begin
      mClearing = 1'b1;
      mCnt      = 0;
      mBurst    = 1'b0;
    end else if (v) begin
      tgt = mBurst ? mPtr : int'(s);
`ifdef DEMUX8_BYTE_EN
      mask = {{8{be[1]}}, {8{be[0]}}};
`else
      mask = 16'hFFFF;
`endif
      newVal    = (mReg[tgt] & ~mask) | (dat & mask);
      mReg[tgt] = newVal;
      if (mask != 16'h0000) expQ.push_back('{edgeCount + 1, tgt, newVal});
      if (ai) begin
        mBurst = 1'b1;
        mPtr   = (tgt + 1) % 8;
      end else begin
        mBurst = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    reset   = 1'b1;
    wrValid = 1'b0;
    clr     = 1'b0;
    autoInc = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: on every falling edge, the write (if any) stamped with the edge
  // just taken must show up as a one-hot upd strobe and the written value.
  always @(negedge clk) begin
    if (monOn) begin
      logic [7:0]  expUpd;
      logic [15:0] expData;
      int          expIdx;
      bit          found;
      expUpd  = 8'h00;
      expData = 16'h0000;
      expIdx  = 0;
      found   = 1'b0;
      while (expQ.size() > 0 && expQ[0].stamp <= edgeCount) begin
        if (expQ[0].stamp == edgeCount) begin
          found   = 1'b1;
          expIdx  = expQ[0].idx;
          expData = expQ[0].data;
          expUpd  = 8'h01 << expIdx;
        end else begin
          compareValue("stale write", expQ[0].stamp, edgeCount);
        end
        void'(expQ.pop_front());
      end
      compareValue("upd", {24'h0, upd}, {24'h0, expUpd});
      if (found) begin
        compareValue($sformatf("write reg%0d", expIdx), {16'h0, dutRegs[expIdx]}, {16'h0, expData});
      end
    end
  end

  initial begin
    reset   = 1'b1;
    in      = 16'h0000;
    sel     = 3'd0;
    wrValid = 1'b0;
    autoInc = 1'b0;
    clr     = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();
    monOn = 1'b1;

    $display("[TB] single write");
    applyStimulus(1, 3'd5, 16'h1234, 0, 0);
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    compareValue("f after write", {16'h0, f}, 32'h1234);

    $display("[TB] burst with wrap");
    applyStimulus(1, 3'd6, 16'hA000, 1, 0);
    applyStimulus(1, 3'd0, 16'hA001, 1, 0);
    applyStimulus(1, 3'd3, 16'hA002, 1, 0);
    applyStimulus(1, 3'd4, 16'hA003, 0, 0);
    applyStimulus(1, 3'd3, 16'hBEEF, 0, 0);
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    compareValue("g burst", {16'h0, g}, 32'hA000);
    compareValue("h burst", {16'h0, h}, 32'hA001);
    compareValue("a wrap", {16'h0, a}, 32'hA002);
    compareValue("b last", {16'h0, b}, 32'hA003);
    compareValue("d sel again", {16'h0, d}, 32'hBEEF);

    $display("[TB] burst with gaps");
    applyStimulus(1, 3'd3, 16'h0D00, 1, 0);
    applyStimulus(0, 3'd0, 16'hFFFF, 1, 0);
    applyStimulus(0, 3'd7, 16'hFFFF, 0, 0);
    applyStimulus(1, 3'd1, 16'h0E00, 1, 0);
    applyStimulus(0, 3'd2, 16'hFFFF, 1, 0);
    applyStimulus(1, 3'd0, 16'h0F00, 0, 0);

    $display("[TB] fill then clear");
    for (int i = 0; i < 8; i++) applyStimulus(1, 3'(i), 16'h1111 * 16'(i + 1), 0, 0);
    applyStimulus(1, 3'd2, 16'hDEAD, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 3'(i), 16'hBAD0, 1, 1'($urandom_range(0, 1)));
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(1, 3'd4, 16'h4444, 1, 0);
    applyStimulus(1, 3'd4, 16'h5555, 1, 0);
    doReset();
    applyStimulus(1, 3'd2, 16'h2222, 0, 0);

    $display("[TB] reset mid-clear");
    applyStimulus(0, 3'd0, 16'h0000, 0, 1);
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    doReset();
    applyStimulus(1, 3'd7, 16'h7777, 0, 0);

`ifdef DEMUX8_BYTE_EN
    $display("[TB] byte enables");
    be = 2'b11;
    applyStimulus(1, 3'd2, 16'hFFFF, 0, 0);
    be = 2'b10;
    applyStimulus(1, 3'd2, 16'h1200, 0, 0);
    be = 2'b00;
    applyStimulus(1, 3'd2, 16'h5555, 0, 0);
    be = 2'b11;
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    compareValue("c byte enable", {16'h0, c}, 32'h12FF);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
`ifdef DEMUX8_BYTE_EN
      be = 2'($urandom_range(0, 3));
`endif
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
    end

    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    applyStimulus(0, 3'd0, 16'h0000, 0, 0);
    compareValue("scoreboard drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
